// File: rtl/router_input_port.sv
// Router input port: FWFT flit buffer with head-flit class decode and
// one-cycle credit return per dequeued flit.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 36
`endif
`ifndef TOT_FIFO_DEPTH
`define TOT_FIFO_DEPTH 4
`endif
`ifndef ROUTER_INFO_BROADCAST
`define ROUTER_INFO_BROADCAST 4'd2
`endif
`ifndef ROUTER_INFO_FIN_BROADCAST
`define ROUTER_INFO_FIN_BROADCAST 4'd3
`endif
`ifndef ROUTER_INFO_FIN_COMP
`define ROUTER_INFO_FIN_COMP 4'd5
`endif

module router_input_port #(
  parameter int DEPTH = `TOT_FIFO_DEPTH,
  parameter int WIDTH = `ROUTER_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           deq,
  output logic                           head_valid,
  output logic [3:0]                     head_info,
  output logic [15:0]                    head_addr,
  output logic [15:0]                    head_data,
  output logic                           head_is_bcast,
  output logic                           head_is_fin,
  output logic                           credit_out,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           ovf_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             credit_q, credit_d;
  logic             ovf_q, ovf_d;

  logic             empty, full, deq_ok, wr_ok, drop;
  logic [WIDTH-1:0] head_flit;

  // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty  = (cnt_q == '0);
    full   = (cnt_q == CW'(DEPTH));
    deq_ok = deq & ~empty;
    // A full buffer can still take a flit when the head leaves this cycle.
    wr_ok  = in_valid & (~full | deq_ok);
    drop   = in_valid & full & ~deq_ok;
  end

  always_comb begin
    wr_ptr_d = wr_ok  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_ok, deq_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    credit_d = deq_ok;
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  // Payload storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    head_flit     = empty ? '0 : mem_q[rd_ptr_q];
    head_valid    = ~empty;
    head_info     = head_flit[35:32];
    head_addr     = head_flit[31:16];
    head_data     = head_flit[15:0];
    head_is_bcast = ~empty & ((head_info == `ROUTER_INFO_BROADCAST) ||
                              (head_info == `ROUTER_INFO_FIN_BROADCAST));
    head_is_fin   = ~empty & ((head_info == `ROUTER_INFO_FIN_BROADCAST) ||
                              (head_info == `ROUTER_INFO_FIN_COMP));
    credit_out    = credit_q;
    occupancy     = cnt_q;
    ovf_err       = ovf_q;
  end

endmodule

// File: tb/tb_router_input_port.sv
// Scoreboard bench: drivers push expected flits, per-instance monitors pop and
// compare the head on every dequeue, plus per-cycle credit/occupancy checks.
`ifndef ROUTER_INFO_BROADCAST
`define ROUTER_INFO_BROADCAST 4'd2
`endif
`ifndef ROUTER_INFO_FIN_BROADCAST
`define ROUTER_INFO_FIN_BROADCAST 4'd3
`endif
`ifndef ROUTER_INFO_FIN_COMP
`define ROUTER_INFO_FIN_COMP 4'd5
`endif

module tb_router_input_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv4 = 1'b0, dq4 = 1'b0, iv3 = 1'b0, dq3 = 1'b0;
  logic [35:0] id4 = '0, id3 = '0;
  logic        hv4, hb4, hf4, co4, ov4, hv3, hb3, hf3, co3, ov3;
  logic [3:0]  hi4, hi3;
  logic [15:0] ha4, hd4, ha3, hd3;
  logic [2:0]  oc4;
  logic [1:0]  oc3;

  router_input_port #(.DEPTH(4), .WIDTH(36)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_data(id4), .deq(dq4),
    .head_valid(hv4), .head_info(hi4), .head_addr(ha4), .head_data(hd4),
    .head_is_bcast(hb4), .head_is_fin(hf4), .credit_out(co4),
    .occupancy(oc4), .ovf_err(ov4));

  router_input_port #(.DEPTH(3), .WIDTH(36)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_data(id3), .deq(dq3),
    .head_valid(hv3), .head_info(hi3), .head_addr(ha3), .head_data(hd3),
    .head_is_bcast(hb3), .head_is_fin(hf3), .credit_out(co3),
    .occupancy(oc3), .ovf_err(ov3));

  int          nvec = 0, nbad = 0;
  logic [35:0] q4[$], q3[$];
  bit          ce4 = 0, ce3 = 0, ovx4 = 0, ovx3 = 0;
  int          cred4 = 0, cred3 = 0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_bc(input logic [3:0] i);
    return (i == `ROUTER_INFO_BROADCAST) || (i == `ROUTER_INFO_FIN_BROADCAST);
  endfunction
  function automatic bit is_fin(input logic [3:0] i);
    return (i == `ROUTER_INFO_FIN_BROADCAST) || (i == `ROUTER_INFO_FIN_COMP);
  endfunction

  task automatic head_chk(input string tag, input logic hv, input logic [35:0] h,
                          input logic [1:0] fl, input bit has, input logic [35:0] e);
    logic [1:0] ef;
    ef = has ? {is_bc(e[35:32]), is_fin(e[35:32])} : 2'b00;
    chk({tag, "_valid"}, 36'(hv), 36'(has));
    chk({tag, "_flit"},  h, has ? e : 36'h0);
    chk({tag, "_flags"}, 36'(fl), 36'(ef));
  endtask

  always @(negedge clk) begin : mon4
    logic [35:0] e;
    if (rst) ce4 = 0;
    else begin
      e = (q4.size() > 0) ? q4[0] : '0;
      chk("credit4", 36'(co4), 36'(ce4));
      if (co4) cred4++;
      chk("occ4", 36'(oc4), 36'(q4.size()));
      chk("ovf4", 36'(ov4), 36'(ovx4));
      head_chk("head4", hv4, {hi4, ha4, hd4}, {hb4, hf4}, q4.size() > 0, e);
      ce4 = dq4 && (q4.size() > 0);
      if (ce4) void'(q4.pop_front());
    end
  end

  always @(negedge clk) begin : mon3
    logic [35:0] e;
    if (rst) ce3 = 0;
    else begin
      e = (q3.size() > 0) ? q3[0] : '0;
      chk("credit3", 36'(co3), 36'(ce3));
      if (co3) cred3++;
      chk("occ3", 36'(oc3), 36'(q3.size()));
      chk("ovf3", 36'(ov3), 36'(ovx3));
      head_chk("head3", hv3, {hi3, ha3, hd3}, {hb3, hf3}, q3.size() > 0, e);
      ce3 = dq3 && (q3.size() > 0);
      if (ce3) void'(q3.pop_front());
    end
  end

  // One cycle on the DEPTH=4 port; the model decides accept/drop from the
  // pre-cycle occupancy.
  task automatic cyc4(input bit v, input logic [35:0] d, input bit dq);
    int sz;
    iv4 = v; id4 = d; dq4 = dq; sz = q4.size();
    @(posedge clk);
    if (v) begin
      if (sz < 4 || (dq && sz > 0)) q4.push_back(d);
      else ovx4 = 1;
    end
    #1 iv4 = 0; dq4 = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #1 q4.delete(); q3.delete(); ovx4 = 0; ovx3 = 0;
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int c0, cr, nxt, stalls;
    #3;
    chk("rst_head4", {hi4, ha4, hd4}, 36'h0);
    chk("rst_ctl4",  36'({hv4, hb4, hf4, co4, oc4, ov4}), 36'h0);
    chk("rst_head3", {hi3, ha3, hd3}, 36'h0);
    chk("rst_ctl3",  36'({hv3, hb3, hf3, co3, oc3, ov3}), 36'h0);
    @(posedge clk);
    #1 rst = 0;
    cyc4(0, '0, 0);

    // Single broadcast flit, then dequeue it.
    cyc4(1, {`ROUTER_INFO_BROADCAST, 16'h0012, 16'hBEEF}, 0);
    chk("single_valid", 36'(hv4), 36'h1);
    chk("single_flags", 36'({hb4, hf4}), 36'h2);
    chk("single_addr",  36'(ha4), 36'h0012);
    chk("single_data",  36'(hd4), 36'hBEEF);
    cyc4(0, '0, 1);
    chk("single_credit", 36'(co4), 36'h1);
    chk("single_empty",  36'(hv4), 36'h0);
    cyc4(0, '0, 0);
    chk("single_credit_end", 36'(co4), 36'h0);

    // Asynchronous reset with three flits stored.
    for (int i = 1; i <= 3; i++) cyc4(1, {4'h0, 16'h0, 16'(i)}, 0);
    chk("pre_rst_occ", 36'(oc4), 36'd3);
    #2 rst = 1;
    #1;
    chk("async_rst_occ",   36'(oc4), 36'h0);
    chk("async_rst_valid", 36'(hv4), 36'h0);
    q4.delete(); ovx4 = 0;
    @(posedge clk);
    #1 rst = 0;

    // Fill, overflow, drain.
    for (int i = 1; i <= 4; i++) cyc4(1, {4'h0, 16'h0, 16'(i)}, 0);
    chk("fill_occ", 36'(oc4), 36'd4);
    chk("fill_ovf", 36'(ov4), 36'h0);
    cyc4(1, {4'h0, 16'h0, 16'd99}, 0);
    chk("ovf_set", 36'(ov4), 36'h1);
    chk("ovf_occ", 36'(oc4), 36'd4);
    chk("drain_first", 36'(hd4), 36'd1);
    c0 = cred4;
    for (int i = 0; i < 4; i++) cyc4(0, '0, 1);
    cyc4(0, '0, 0);
    chk("drain_credits", 36'(cred4 - c0), 36'd4);
    chk("ovf_sticky", 36'(ov4), 36'h1);
    do_reset();

    // Full with simultaneous write and dequeue.
    for (int i = 1; i <= 4; i++) cyc4(1, {4'h0, 16'h0, 16'(i)}, 0);
    c0 = cred4;
    cyc4(1, {4'h0, 16'h0, 16'd5}, 1);
    chk("full_rw_occ",    36'(oc4), 36'd4);
    chk("full_rw_ovf",    36'(ov4), 36'h0);
    chk("full_rw_head",   36'(hd4), 36'd2);
    chk("full_rw_credit", 36'(co4), 36'h1);
    for (int i = 0; i < 4; i++) cyc4(0, '0, 1);
    cyc4(0, '0, 0);
    chk("full_rw_credits", 36'(cred4 - c0), 36'd5);

    // Dequeue while empty, then simultaneous write+deq on empty.
    c0 = cred4;
    for (int i = 0; i < 5; i++) cyc4(0, '0, 1);
    cyc4(0, '0, 0);
    chk("empty_deq_credits", 36'(cred4 - c0), 36'd0);
    chk("empty_deq_occ", 36'(oc4), 36'h0);
    cyc4(1, {`ROUTER_INFO_FIN_COMP, 16'h00AB, 16'h1234}, 1);
    chk("empty_rw_occ",   36'(oc4), 36'd1);
    chk("empty_rw_flags", 36'({hb4, hf4}), 36'h1);
    chk("empty_rw_data",  36'(hd4), 36'h1234);
    chk("empty_rw_credit", 36'(co4), 36'h0);
    cyc4(0, '0, 0);
    chk("empty_rw_credits", 36'(cred4 - c0), 36'd0);
    cyc4(0, '0, 1);
    cyc4(0, '0, 0);

    // Wrap on DEPTH=3 with a sender holding 3 credits.
    cr = 3; nxt = 0; stalls = 0; c0 = cred3;
    for (int c = 0; c < 14; c++) begin
      bit s;
      int sz;
      s = (nxt < 10) && (cr > 0);
      if (nxt < 10 && !s && c > 0) stalls++;
      if (s) cr--;
      iv3 = s; id3 = {4'h1, 16'h0300, 16'(nxt)}; dq3 = 1; sz = q3.size();
      @(negedge clk);
      if (co3) cr++;
      @(posedge clk);
      if (s) begin
        if (sz < 3 || sz > 0) q3.push_back(id3);
        else ovx3 = 1;
      end
      #1 iv3 = 0; dq3 = 0;
      if (s) nxt++;
    end
    chk("wrap_sent",    36'(nxt), 36'd10);
    chk("wrap_stalls",  36'(stalls), 36'd0);
    chk("wrap_credits", 36'(cred3 - c0), 36'd10);
    chk("wrap_occ",     36'(oc3), 36'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/router_input_port.md
# router_input_port

Input port of the leaf router that receives flits produced by the PE network-interface output stage. It buffers incoming flits in a first-word-fall-through FIFO, exposes the head flit with its packet class pre-decoded to the router switch allocator, and returns one credit pulse per dequeued flit. These pulses keep the sender's credit counter consistent. Buffer depth equals the sender's initial credit count, so a protocol-correct sender never overflows it.

## Interface
Parameters:
- DEPTH, `TOT_FIFO_DEPTH: flit slots; must equal the sender's credit reset value; ≥2.
- WIDTH, `ROUTER_WIDTH (36): flit width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  flit present on in_data this cycle.
- in_data  in  WIDTH  flit: [35:32] info, [31:16] addr, [15:0] data.
- deq  in  1  switch allocator consumes head flit this cycle.
- head_valid  out  1  FIFO non-empty.
- head_info  out  4  head [35:32].
- head_addr  out  16  head [31:16].
- head_data  out  16  head [15:0].
- head_is_bcast  out  1  head_valid & info ∈ {`ROUTER_INFO_BROADCAST, `ROUTER_INFO_FIN_BROADCAST}.
- head_is_fin  out  1  head_valid & info ∈ {`ROUTER_INFO_FIN_BROADCAST, `ROUTER_INFO_FIN_COMP}.
- credit_out  out  1  one-cycle credit pulse to the upstream sender.
- occupancy  out  $clog2(DEPTH+1)  stored flit count.
- ovf_err  out  1  sticky overflow flag.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer, read pointer and count. Pointers wrap from DEPTH-1 to 0. Wrap must also work for non-power-of-two DEPTH.
- Write: when in_valid=1 and the write is accepted, in_data is stored at wr_ptr, then wr_ptr advances.
  - Accepted if count<DEPTH.
  - Also accepted if count==DEPTH and a valid deq occurs in the same cycle.
- Overflow: in_valid=1 while count==DEPTH with no valid deq → flit dropped, ovf_err set to 1. ovf_err is cleared only by rst.
- Read: deq is valid only when head_valid=1; rd_ptr then advances.
  - deq while empty is ignored: no pointer change, no credit.
- Head fields are combinational from the array entry at rd_ptr (FWFT). All head outputs are 0 when empty.
- Count update: +1 on an accepted write only, −1 on a valid deq only, unchanged when both or neither occur.
- Empty with simultaneous in_valid and deq: deq is ignored and the flit is stored (count→1). There is no bypass.
- Credit: credit_out is a register, set to 1 in the cycle after each valid deq and 0 otherwise. Back-to-back deqs give back-to-back pulses. No credit is returned for dropped flits.
- Decode flags depend only on head_info; addr and data pass through unmodified.
- Reset mid-operation discards all contents immediately; the sender must reset concurrently.

## Timing
- Reset values:
  - head_valid, head_info, head_addr, head_data, head_is_bcast, head_is_fin = 0.
  - credit_out = 0, occupancy = 0, ovf_err = 0.
  - Pointers = 0.
- Write latency: flit sampled at edge t appears at the head at t+1 if the FIFO was empty.
- Deq at cycle t: next head visible after edge t; credit_out high during cycle t+1 only.
- Full-throughput: one write plus one deq per cycle sustains indefinitely with constant occupancy.
- No combinational path from in_valid or in_data to any output. There is also no combinational path from deq to credit_out. The head outputs depend only on registered state.

## Test plan
- Reset then idle:
  - All outputs 0.
  - Assert rst asynchronously mid-cycle with 3 flits stored → occupancy=0 and head_valid=0 immediately, before the next edge.
- Single flit {info=`ROUTER_INFO_BROADCAST, addr=0x0012, data=0xBEEF}:
  - Next cycle: head_valid=1, head_is_bcast=1, head_is_fin=0, head_addr=0x0012, head_data=0xBEEF.
  - deq → credit_out=1 exactly one cycle later, then head_valid=0.
- DEPTH=4, write 4 flits (data 1..4) without deq:
  - occupancy=4, ovf_err=0.
  - A 5th write → dropped, ovf_err=1 and stays 1.
  - Dequeue all → data order 1,2,3,4, 4 credit pulses.
- Full FIFO (DEPTH=4) with simultaneous write (data 5) and deq:
  - Flit 5 accepted, occupancy stays 4, one credit returned, ovf_err stays 0.
  - Drain order 2,3,4,5.
- Wrap-around: 10 cycles of continuous write+deq with DEPTH=3, data 0..9:
  - Output order preserved, 10 credits returned.
  - Paired with a sender credit model starting at 3, the sender never stalls after the first fill.
- deq while empty for 5 cycles:
  - No credit pulses, pointers unchanged.
  - Empty-state simultaneous write+deq → occupancy=1, no credit.
  - Head `ROUTER_INFO_FIN_COMP` → head_is_fin=1, head_is_bcast=0.
